// File: rtl/fetch_aligner_if.sv
// ---------------------------------------------------------------------------
// fetch_aligner_if
//   Bundles the fetch-word handshake, the instruction handshake towards the
//   compressed decoder and the redirect/flush request of fetch_aligner.
//   Signal names carry the aligner's point of view (_i into the aligner,
//   _o out of it).
//   slave  : the aligner itself
//   master : the surrounding environment (prefetch buffer, decoder, redirect)
// ---------------------------------------------------------------------------
interface fetch_aligner_if;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_is_compressed_o;
  logic        flush_i;
  logic [31:0] flush_pc_i;

  modport slave (
    input  fetch_valid_i, fetch_rdata_i, instr_ready_i, flush_i, flush_pc_i,
    output fetch_ready_o, instr_valid_o, instr_o, instr_pc_o, instr_is_compressed_o
  );

  modport master (
    output fetch_valid_i, fetch_rdata_i, instr_ready_i, flush_i, flush_pc_i,
    input  fetch_ready_o, instr_valid_o, instr_o, instr_pc_o, instr_is_compressed_o
  );
endinterface

// File: rtl/fetch_aligner.sv
// ---------------------------------------------------------------------------
// fetch_aligner
//   Splits word-aligned 32-bit fetch words into individual instructions
//   (16-bit RVC or 32-bit, the latter possibly spanning two words) and tracks
//   the PC of each emitted instruction. Redirects may target any halfword.
//   Instruction outputs are combinational from state, the buffered halfword
//   and the current fetch word (zero latency).
// Ports
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   bus     : fetch_aligner_if.slave
//             fetch_valid_i/fetch_ready_o/fetch_rdata_i : fetch word in
//             instr_valid_o/instr_ready_i/instr_o/instr_pc_o/
//             instr_is_compressed_o                      : instruction out
//             flush_i/flush_pc_i                         : redirect
// Parameters
//   BOOT_ADDR : PC after reset (bit0 must be 0)
//   C_EXT_EN  : 1 = RVC supported, 0 = every instruction is 32-bit
// ---------------------------------------------------------------------------
module fetch_aligner #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter bit          C_EXT_EN  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  fetch_aligner_if.slave   bus
);

  typedef enum logic [1:0] {
    S_ALIGNED = 2'd0,  // next instruction starts at the low half of a fetch word
    S_HALF    = 2'd1,  // next instruction starts at hw_q (upper half of previous word)
    S_SKIP    = 2'd2   // redirect to an odd halfword: drop low half of next word
  } state_e;

  // Without RVC, PC bit 1 is never set.
  localparam logic [31:0] PC_MASK     = C_EXT_EN ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
  localparam state_e      RESET_STATE = (BOOT_ADDR[1] && C_EXT_EN) ? S_SKIP : S_ALIGNED;

  state_e      state_q, state_d;
  logic [15:0] hw_q, hw_d;
  logic [31:0] pc_q, pc_d;

  logic        valid_s;
  logic        ready_s;
  logic [31:0] instr_s;
  logic        lo_rvc_s;
  logic        hw_rvc_s;
  logic        instr_fire_s;
  logic        fetch_fire_s;

  assign lo_rvc_s = C_EXT_EN && (bus.fetch_rdata_i[1:0] != 2'b11);
  assign hw_rvc_s = C_EXT_EN && (hw_q[1:0] != 2'b11);

  // Fire signals are formed from the ungated valid/ready; reset clears state anyway.
  assign instr_fire_s = valid_s && bus.instr_ready_i;
  assign fetch_fire_s = bus.fetch_valid_i && ready_s;

  // Output decode and next-state computation.
  always_comb begin
    valid_s = 1'b0;
    ready_s = 1'b0;
    instr_s = bus.fetch_rdata_i;
    state_d = state_q;
    hw_d    = hw_q;
    pc_d    = pc_q;

    if (bus.flush_i) begin
      // Redirect wins over everything; any presented word is dropped.
      valid_s = 1'b0;
      ready_s = 1'b1;
      hw_d    = 16'h0000;
      pc_d    = bus.flush_pc_i & PC_MASK;
      if (C_EXT_EN && bus.flush_pc_i[1]) begin
        state_d = S_SKIP;
      end else begin
        state_d = S_ALIGNED;
      end
    end else begin
      case (state_q)
        S_ALIGNED: begin
          valid_s = bus.fetch_valid_i;
          ready_s = bus.instr_ready_i;
          if (lo_rvc_s) begin
            instr_s = {16'h0000, bus.fetch_rdata_i[15:0]};
            if (instr_fire_s) begin
              hw_d    = bus.fetch_rdata_i[31:16];
              pc_d    = pc_q + 32'd2;
              state_d = S_HALF;
            end else begin
              state_d = S_ALIGNED;
            end
          end else begin
            instr_s = bus.fetch_rdata_i;
            if (instr_fire_s) begin
              pc_d = pc_q + 32'd4;
            end else begin
              pc_d = pc_q;
            end
          end
        end
        S_HALF: begin
          if (hw_rvc_s) begin
            // Buffered halfword is a whole instruction: no fetch word needed.
            valid_s = 1'b1;
            ready_s = 1'b0;
            instr_s = {16'h0000, hw_q};
            if (instr_fire_s) begin
              pc_d    = pc_q + 32'd2;
              state_d = S_ALIGNED;
            end else begin
              state_d = S_HALF;
            end
          end else begin
            // Spanning instruction: upper half comes from the new word.
            valid_s = bus.fetch_valid_i;
            ready_s = bus.instr_ready_i;
            instr_s = {bus.fetch_rdata_i[15:0], hw_q};
            if (instr_fire_s) begin
              hw_d = bus.fetch_rdata_i[31:16];
              pc_d = pc_q + 32'd4;
            end else begin
              hw_d = hw_q;
            end
          end
        end
        S_SKIP: begin
          valid_s = 1'b0;
          ready_s = 1'b1;
          if (fetch_fire_s) begin
            hw_d    = bus.fetch_rdata_i[31:16];
            state_d = S_HALF;
          end else begin
            state_d = S_SKIP;
          end
        end
        default: begin
          state_d = S_ALIGNED;
        end
      endcase
    end
  end

  // State, buffered halfword and PC registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RESET_STATE;
      hw_q    <= 16'h0000;
      pc_q    <= BOOT_ADDR & PC_MASK;
    end else begin
      state_q <= state_d;
      hw_q    <= hw_d;
      pc_q    <= pc_d;
    end
  end

  // Handshakes are forced low while reset is asserted.
  assign bus.instr_valid_o         = valid_s && rst_ni;
  assign bus.fetch_ready_o         = ready_s && rst_ni;
  assign bus.instr_o               = instr_s;
  assign bus.instr_pc_o            = pc_q;
  assign bus.instr_is_compressed_o = C_EXT_EN && (instr_s[1:0] != 2'b11);

endmodule
